// File: rtl/srv6_pkg.sv
// rtl/srv6_pkg.sv - shared SRv6 beat geometry, IPv6 header field offsets and egress FSM states
package srv6_pkg;
   localparam int BEAT_BYTES = 64;
   localparam int BEAT_W     = BEAT_BYTES * 8;
   localparam int PLEN_LSB   = 464;
   localparam int NH_LSB     = 456;
   localparam int HOP_LSB    = 448;

   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

   // 17-bit sum so payload_length 0xFFFF yields 1024 beats; zero-length still occupies the header beat
   function automatic logic [10:0] beats_for(input logic [15:0] plen);
      logic [16:0] sum;
      sum = {1'b0, plen} + 17'd63;
      beats_for = (sum[16:6] == 11'd0) ? 11'd1 : sum[16:6];
   endfunction
endpackage

// File: rtl/srv6_egress_fifo.sv
// rtl/srv6_egress_fifo.sv - first-word-fall-through beat buffer, word = {sop, eop, data}
module srv6_egress_fifo #(
   parameter int FIFO_AW = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [513:0]       wr_data,
   input  logic               rd_en,
   output logic [513:0]       rd_data,
   output logic               rd_valid,
   output logic [FIFO_AW:0]   count
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

   logic [513:0]       mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               rd_fire;

   assign rd_valid = (count != '0);
   assign rd_fire  = rd_en && rd_valid;
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
         count <= count + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, rd_fire};
      end
   end
endmodule

// File: rtl/srv6_egress.sv
// rtl/srv6_egress.sv - SRv6 egress admission/drop FSM with FWFT buffer; SRV6_EGRESS_HOPLIMIT_EN enables hop-limit check
module srv6_egress import srv6_pkg::*; #(
   parameter int FIFO_AW = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BEAT_W-1:0] din,
   input  logic              we,
   output logic [BEAT_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_sop,
   output logic              dout_eop,
   input  logic              dout_ready,
   output logic [31:0]       drop_count,
   output logic [31:0]       ovf_count
);
   localparam int DEPTH = 2 ** FIFO_AW;

   state_t             state;
   logic [10:0]        n_beats;
   logic [10:0]        beat_cnt;
   logic [10:0]        hdr_beats;
   logic [FIFO_AW:0]   fifo_count;
   logic [31:0]        free_cnt;
   logic               no_space;
   logic               last_beat;
   logic               hop_fail;
   logic [BEAT_W-1:0]  hdr_data;
   logic               wr_en;
   logic [513:0]       wr_word;
   logic [513:0]       rd_word;

   assign hdr_beats = beats_for(din[PLEN_LSB +: 16]);
   // a read in this same cycle is not counted as freed space
   assign free_cnt  = 32'(DEPTH) - 32'(fifo_count);
   assign no_space  = free_cnt < 32'(hdr_beats);
   assign last_beat = (beat_cnt + 11'd1) == n_beats;

`ifdef SRV6_EGRESS_HOPLIMIT_EN
   assign hop_fail = din[HOP_LSB +: 8] <= 8'd1;
   always_comb begin
      hdr_data = din;
      hdr_data[HOP_LSB +: 8] = din[HOP_LSB +: 8] - 8'd1;
   end
`else
   assign hop_fail = 1'b0;
   assign hdr_data = din;
`endif

   always_comb begin
      wr_en   = 1'b0;
      wr_word = {2'b00, din};
      if (reset && we) begin
         if (state == ST_IDLE && !hop_fail && !no_space) begin
            wr_en   = 1'b1;
            wr_word = {1'b1, hdr_beats == 11'd1, hdr_data};
         end else if (state == ST_PASS) begin
            wr_en   = 1'b1;
            wr_word = {1'b0, last_beat, din};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         n_beats    <= '0;
         beat_cnt   <= '0;
         drop_count <= '0;
         ovf_count  <= '0;
      end else if (we) begin
         case (state)
            ST_IDLE: begin
               n_beats  <= hdr_beats;
               beat_cnt <= 11'd1;
               if (hop_fail) begin
                  if (drop_count != '1) drop_count <= drop_count + 32'd1;
               end else if (no_space) begin
                  if (ovf_count != '1) ovf_count <= ovf_count + 32'd1;
               end
               if (hdr_beats != 11'd1)
                  state <= (hop_fail || no_space) ? ST_DROP : ST_PASS;
            end
            ST_PASS, ST_DROP: begin
               beat_cnt <= beat_cnt + 11'd1;
               if (last_beat) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   srv6_egress_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_word),
      .rd_en    (dout_ready),
      .rd_data  (rd_word),
      .rd_valid (dout_valid),
      .count    (fifo_count)
   );

   assign dout     = rd_word[511:0];
   assign dout_eop = rd_word[512];
   assign dout_sop = rd_word[513];
endmodule

// File: tb/tb_srv6_egress.sv
// tb/tb_srv6_egress.sv - directed bench for srv6_egress, default and FIFO_AW=2 instances
module tb_srv6_egress;
   logic         clk = 1'b0;
   logic         reset;
   logic [511:0] din, din_s;
   logic         we, we_s;
   logic [511:0] dout, dout_s;
   logic         dout_valid, dout_sop, dout_eop, dout_ready;
   logic         valid_s, sop_s, eop_s, ready_s;
   logic [31:0]  drop_count, ovf_count, drop_s, ovf_s;

   int checks = 0;
   int errors = 0;

`ifdef SRV6_EGRESS_HOPLIMIT_EN
   localparam logic [7:0] HOP_DEC = 8'd1;
`else
   localparam logic [7:0] HOP_DEC = 8'd0;
`endif

   logic [513:0] cap[$];
   logic [513:0] cap_s[$];
   logic [513:0] expq[$];
   logic         stall_q = 1'b0;
   logic [513:0] held;

   always #5 clk = ~clk;

   srv6_egress dut (
      .clk(clk), .reset(reset), .din(din), .we(we),
      .dout(dout), .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
      .dout_ready(dout_ready), .drop_count(drop_count), .ovf_count(ovf_count)
   );

   srv6_egress #(.FIFO_AW(2)) dut_s (
      .clk(clk), .reset(reset), .din(din_s), .we(we_s),
      .dout(dout_s), .dout_valid(valid_s), .dout_sop(sop_s), .dout_eop(eop_s),
      .dout_ready(ready_s), .drop_count(drop_s), .ovf_count(ovf_s)
   );

   task automatic check(input string tag, input logic [513:0] got, input logic [513:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && dout_valid && stall_q)
         check("hold", {dout_sop, dout_eop, dout}, held);
      if (dout_valid && dout_ready) cap.push_back({dout_sop, dout_eop, dout});
      if (valid_s && ready_s) cap_s.push_back({sop_s, eop_s, dout_s});
      stall_q = reset && dout_valid && !dout_ready;
      held    = {dout_sop, dout_eop, dout};
   end

   function automatic logic [511:0] hdr(input logic [15:0] plen, input logic [7:0] hop, input logic [15:0] tag);
      logic [511:0] d;
      d = '0;
      d[479:464] = plen;
      d[463:456] = 8'd43;
      d[455:448] = hop;
      d[15:0]    = tag;
      return d;
   endfunction

   function automatic logic [511:0] pay(input logic [15:0] tag, input int i);
      logic [15:0] w;
      w = tag + 16'(i);
      return {32{w}};
   endfunction

   task automatic beat(input logic [511:0] d, input bit sm);
      if (sm) begin din_s = d; we_s = 1'b1; end
      else    begin din   = d; we   = 1'b1; end
      @(posedge clk); #1;
      we = 1'b0; we_s = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] plen, input logic [7:0] hop, input logic [15:0] tag,
                           input int n, input bit keep, input bit sm);
      logic [511:0] h;
      h = hdr(plen, hop, tag);
      beat(h, sm);
      if (keep) begin
         h[455:448] = hop - HOP_DEC;
         expq.push_back({1'b1, n == 1, h});
      end
      for (int i = 1; i < n; i++) begin
         beat(pay(tag, i), sm);
         if (keep) expq.push_back({1'b0, i == n - 1, pay(tag, i)});
      end
   endtask

   task automatic verify(input string tag, input bit sm);
      int n;
      n = sm ? cap_s.size() : cap.size();
      check({tag, "_count"}, 514'(n), 514'(expq.size()));
      for (int i = 0; i < expq.size() && i < n; i++)
         check($sformatf("%s_beat%0d", tag, i), sm ? cap_s[i] : cap[i], expq[i]);
      expq.delete(); cap.delete(); cap_s.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; we = 1'b0; we_s = 1'b0; din = '0; din_s = '0;
      dout_ready = 1'b0; ready_s = 1'b0;
      wait_cycles(3);
      check("rst_valid", 514'(dout_valid), 514'(0));
      check("rst_dout", 514'(dout), 514'(0));
      check("rst_sop", 514'(dout_sop), 514'(0));
      check("rst_eop", 514'(dout_eop), 514'(0));
      check("rst_drop", 514'(drop_count), 514'(0));
      check("rst_ovf", 514'(ovf_count), 514'(0));
      reset = 1'b1;
      dout_ready = 1'b1;
      wait_cycles(1);

      // 256-byte payload, hop 64: four beats
      send_pkt(16'd256, 8'd64, 16'h0100, 4, 1'b1, 1'b0);
      wait_cycles(8);
      check("t1_hop", 514'((cap.size() > 0) ? cap[0][455:448] : 8'hxx), 514'(8'd64 - HOP_DEC));
      verify("t1", 1'b0);

      // two single-beat packets back to back
      send_pkt(16'd40, 8'd10, 16'h0200, 1, 1'b1, 1'b0);
      send_pkt(16'd40, 8'd10, 16'h0201, 1, 1'b1, 1'b0);
      wait_cycles(6);
      verify("t2", 1'b0);

      // hop limit 1
      send_pkt(16'd128, 8'd1, 16'h0300, 2, HOP_DEC == 8'd0, 1'b0);
      wait_cycles(6);
      verify("t3", 1'b0);
      check("t3_drop", 514'(drop_count), 514'(HOP_DEC));
      check("t3_ovf", 514'(ovf_count), 514'(0));

      // small FIFO, stalled output: second packet has no room
      send_pkt(16'd192, 8'd64, 16'h0400, 3, 1'b1, 1'b1);
      send_pkt(16'd192, 8'd64, 16'h0401, 3, 1'b0, 1'b1);
      wait_cycles(3);
      check("t4_ovf", 514'(ovf_s), 514'(1));
      check("t4_drop", 514'(drop_s), 514'(0));
      check("t4_valid", 514'(valid_s), 514'(1));
      ready_s = 1'b1;
      wait_cycles(8);
      verify("t4", 1'b1);

      // ready toggling every cycle
      dout_ready = 1'b0;
      fork
         send_pkt(16'd320, 8'd20, 16'h0500, 5, 1'b1, 1'b0);
         begin
            repeat (30) begin
               dout_ready = ~dout_ready;
               @(posedge clk); #1;
            end
         end
      join
      dout_ready = 1'b1;
      wait_cycles(10);
      verify("t5", 1'b0);

      // reset in the middle of a packet
      dout_ready = 1'b0;
      beat(hdr(16'd256, 8'd50, 16'h0600), 1'b0);
      beat(pay(16'h0600, 1), 1'b0);
      reset = 1'b0;
      wait_cycles(1);
      check("t6_valid", 514'(dout_valid), 514'(0));
      check("t6_drop", 514'(drop_count), 514'(0));
      check("t6_ovf", 514'(ovf_count), 514'(0));
      check("t6_ovf_s", 514'(ovf_s), 514'(0));
      reset = 1'b1;
      dout_ready = 1'b1;
      wait_cycles(1);
      send_pkt(16'd256, 8'd50, 16'h0610, 4, 1'b1, 1'b0);
      wait_cycles(8);
      verify("t6", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/srv6_egress.md
SRV6_EGRESS -- requirements
Module: srv6_egress

Interface
REQ-001 SHALL have parameter FIFO_AW, default 6, FIFO address width; depth = 2**FIFO_AW beats.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port din  input  512  beat from SRv6 stage; first beat of packet = IPv6 header beat.
REQ-005 SHALL have port we  input  1  din valid; no backpressure toward upstream.
REQ-006 SHALL have port dout  output  512  egress beat.
REQ-007 SHALL have port dout_valid  output  1  dout holds a beat.
REQ-008 SHALL have ports dout_sop and dout_eop  output  1 each  first/last beat markers, qualified by dout_valid.
REQ-009 SHALL have port dout_ready  input  1  beat transferred when dout_valid && dout_ready.
REQ-010 SHALL have ports drop_count and ovf_count  output  32 each  packets dropped for hop limit / FIFO space.

Function
REQ-011 SHALL run FSM IDLE, PASS, DROP; header beat = first we beat seen in IDLE.
REQ-012 SHALL compute beat count N = max(1, ceil(payload_length/64)), payload_length = din[479:464], 17-bit arithmetic, no overflow at 0xFFFF (N = 1024).
REQ-013 SHALL, in IDLE on header, go DROP if hop check fails (REQ-026) or free FIFO entries < N; otherwise write header, go PASS; if N = 1, stay IDLE.
REQ-014 SHALL write each PASS beat into FIFO with sop (header only) and eop (beat N) flags; return to IDLE after beat N.
REQ-015 SHALL discard DROP beats, return to IDLE after beat N, and increment exactly one of drop_count (hop) or ovf_count (space, hop check passed), each saturating at 0xFFFFFFFF.
REQ-016 SHALL make FIFO first-word-fall-through: a written beat is visible on dout with dout_valid the cycle after write.
REQ-017 SHALL hold dout/sop/eop stable while dout_valid && !dout_ready.
REQ-018 SHALL support simultaneous write and read in one cycle, including at full and at empty (empty: beat appears next cycle).
REQ-019 SHALL count free space at header time including the read occurring that cycle as not yet freed.
REQ-020 SHALL never write into a full FIFO (guaranteed by REQ-013 admission).
REQ-021 SHALL ignore cycles with we = 0 mid-packet (gaps allowed; beat counter does not advance).

Reset
REQ-022 SHALL, while reset = 0 at a clk edge, set FSM IDLE, FIFO empty, dout_valid/sop/eop = 0, dout = 0, drop_count = ovf_count = 0.
REQ-023 SHALL discard any partial packet on reset mid-operation; no eop emitted for it.
REQ-024 SHALL ignore we during the reset cycle.

Configuration
REQ-025 SHALL key hop-limit handling on macro SRV6_EGRESS_HOPLIMIT_EN.
REQ-026 SHALL, with SRV6_EGRESS_HOPLIMIT_EN defined, drop when din[455:448] <= 1, else write header with din[455:448] decremented by 1.
REQ-027 SHALL, without SRV6_EGRESS_HOPLIMIT_EN, pass hop limit unchanged, never drop for hop limit; drop_count constant 0.

Structure
REQ-028 SHALL take from shared package srv6_pkg: beat bytes (64), header field bit offsets (payload_length, hop_limit, next_header), FSM state enum.
REQ-029 SHALL implement buffer as sub-module srv6_egress_fifo (514-bit words: data + sop + eop, FWFT, parameter FIFO_AW).

Verification
REQ-030 SHALL cover: payload_length 256, hop 64, dout_ready = 1 -> 4 beats out, sop on 1, eop on 4, hop field 63.
REQ-031 SHALL cover: payload_length 40, hop 10 -> 1 beat, sop = eop = 1, hop 9, FSM back to IDLE same cycle.
REQ-032 SHALL cover: hop 1, payload_length 128 (macro on) -> nothing out, drop_count = 1; macro off -> 2 beats out, hop 1.
REQ-033 SHALL cover: FIFO_AW 2, dout_ready = 0, two 192-byte packets -> first admitted (3 beats), second dropped, ovf_count = 1.
REQ-034 SHALL cover: dout_ready toggling 1/0 per cycle with 5-beat packet -> all 5 beats in order, dout stable while stalled.
REQ-035 SHALL cover: reset asserted after beat 2 of 4 -> dout_valid 0 next cycle, counters 0, next packet passes intact.
